// File: rtl/fifo_wptr_full_if.sv
// Bundles the write-side FIFO pointer/flag signals between the write-domain
// logic and the pointer generator.
interface fifo_wptr_full_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  w_inc;
  logic [ADDR_WIDTH:0]   wq2_r_ptr;
  logic                  w_ovf_clr;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH:0]   w_ptr;
  logic                  w_full;
  logic                  w_almost_full;
  logic [ADDR_WIDTH:0]   w_level;
  logic                  w_overflow;

  // Environment side: issues writes and supplies the synchronised read pointer.
  modport master (
    output w_inc, wq2_r_ptr, w_ovf_clr,
    input  w_addr, w_ptr, w_full, w_almost_full, w_level, w_overflow
  );

  // Pointer generator side.
  modport slave (
    input  w_inc, wq2_r_ptr, w_ovf_clr,
    output w_addr, w_ptr, w_full, w_almost_full, w_level, w_overflow
  );
endinterface

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer, full, fill-level, almost-full and sticky-overflow
// generator for an asynchronous FIFO.
module fifo_wptr_full #(
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 12
) (
  input logic              w_clk,
  input logic              w_rst,
  fifo_wptr_full_if.slave  bus
);
  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] r_bin;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_level;
  logic          r_full;
  logic          r_almost_full;
  logic          r_overflow;

  logic          w_wr;
  logic [PW-1:0] w_bin_next;
  logic [PW-1:0] w_gray_next;
  logic [PW-1:0] w_rd_bin;
  logic [PW-1:0] w_full_cmp;
  logic [PW-1:0] w_level_next;

  assign w_wr        = bus.w_inc & ~r_full;
  assign w_bin_next  = r_bin + PW'(w_wr);
  assign w_gray_next = (w_bin_next >> 1) ^ w_bin_next;

  // Each binary bit is the XOR of all Gray bits at or above it; written as a
  // reduction per bit so no bit depends on another bit of the same vector.
  // NOTE: every bit is assigned on every pass, so no latch can be inferred.
  always_comb begin
    w_rd_bin = '0;
    for (int i = 0; i < PW; i++) begin
      w_rd_bin[i] = ^(bus.wq2_r_ptr >> i);
    end
  end

  // Full when the write pointer has lapped the read pointer exactly once:
  // top two Gray bits inverted, the rest identical.
  assign w_full_cmp   = {~bus.wq2_r_ptr[ADDR_WIDTH:ADDR_WIDTH-1],
                         bus.wq2_r_ptr[ADDR_WIDTH-2:0]};
  assign w_level_next = w_bin_next - w_rd_bin;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its inputs, independent of statement order.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_bin         <= '0;
      r_ptr         <= '0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_level       <= '0;
      r_overflow    <= 1'b0;
    end else begin
      r_bin         <= w_bin_next;
      r_ptr         <= w_gray_next;
      r_full        <= (w_gray_next == w_full_cmp);
      r_level       <= w_level_next;
      r_almost_full <= (w_level_next >= PW'(AFULL_THRESH));
      // Set takes priority over clear when both happen in one cycle.
      if (bus.w_inc && r_full) begin
        r_overflow <= 1'b1;
      end else if (bus.w_ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign bus.w_addr        = r_bin[ADDR_WIDTH-1:0];
  assign bus.w_ptr         = r_ptr;
  assign bus.w_full        = r_full;
  assign bus.w_almost_full = r_almost_full;
  assign bus.w_level       = r_level;
  assign bus.w_overflow    = r_overflow;
endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed self-checking bench for fifo_wptr_full with ADDR_WIDTH=4,
// AFULL_THRESH=12.
module tb_fifo_wptr_full;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  fifo_wptr_full_if #(.ADDR_WIDTH(4)) bus ();

  fifo_wptr_full #(
    .ADDR_WIDTH  (4),
    .AFULL_THRESH(12)
  ) dut (
    .w_clk(clk),
    .w_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Packed view of every output: {addr[4], ptr[5], full, afull, level[5], ovf}
  logic [16:0] obs;
  assign obs = {bus.w_addr, bus.w_ptr, bus.w_full, bus.w_almost_full,
                bus.w_level, bus.w_overflow};

  function automatic logic [4:0] gray(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic logic [16:0] pack(input int wr_cnt, input int lvl,
                                       input logic full, input logic ovf);
    logic [3:0] a;
    a = 4'(wr_cnt);
    return {a, gray(wr_cnt), full, (lvl >= 12), 5'(lvl), ovf};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst           = 1'b1;
    bus.w_inc     = 1'b0;
    bus.w_ovf_clr = 1'b0;
    bus.wq2_r_ptr = '0;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (obs !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected %h", obs, 17'd0);
    end
    step();
    n_checks++;
    if (obs !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_idle: got %h expected %h", obs, 17'd0);
    end
  endtask

  task automatic test_reset_midcycle();
    logic [16:0] exp;
    apply_reset();
    bus.w_inc = 1'b1;
    repeat (3) step();
    bus.w_inc = 1'b0;
    exp = pack(3, 3, 1'b0, 1'b0);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL pre_midreset: got %h expected %h", obs, exp);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (obs !== 17'd0) begin
      n_fail++;
      $display("FAIL midcycle_reset: got %h expected %h", obs, 17'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_fill_and_overflow();
    logic [16:0] exp;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      bus.w_inc = 1'b1;
      #0;
      n_checks++;
      if (bus.w_addr !== 4'(i)) begin
        n_fail++;
        $display("FAIL fill_addr[%0d]: got %0d expected %0d", i, bus.w_addr, i);
      end
      step();
      exp = pack(i + 1, i + 1, (i == 15), 1'b0);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL fill_state[%0d]: got %h expected %h", i, obs, exp);
      end
    end
    n_checks++;
    if (bus.w_ptr !== 5'b11000) begin
      n_fail++;
      $display("FAIL fill_ptr_final: got %b expected 11000", bus.w_ptr);
    end
    // Write while full: only overflow reacts.
    step();
    exp = pack(16, 16, 1'b1, 1'b1);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL ovf_set: got %h expected %h", obs, exp);
    end
    bus.w_inc     = 1'b0;
    bus.w_ovf_clr = 1'b1;
    step();
    n_checks++;
    if (bus.w_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got %b expected 0", bus.w_overflow);
    end
    bus.w_inc = 1'b1;
    step();
    n_checks++;
    if (bus.w_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set_wins: got %b expected 1", bus.w_overflow);
    end
    bus.w_inc = 1'b0;
    step();
    bus.w_ovf_clr = 1'b0;
    exp = pack(16, 16, 1'b1, 1'b0);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL ovf_cleared_full: got %h expected %h", obs, exp);
    end
  endtask

  // Continues from the full state left by test_fill_and_overflow.
  task automatic test_drain();
    logic [16:0] exp;
    for (int r = 1; r <= 5; r++) begin
      bus.wq2_r_ptr = gray(r);
      step();
      exp = pack(16, 16 - r, 1'b0, 1'b0);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL drain[%0d]: got %h expected %h", r, obs, exp);
      end
    end
  endtask

  task automatic test_wrap();
    logic [16:0] exp;
    apply_reset();
    bus.w_inc = 1'b1;
    repeat (3) step();
    for (int j = 0; j < 40; j++) begin
      bus.wq2_r_ptr = gray(j + 1);
      step();
      exp = pack(4 + j, 3, 1'b0, 1'b0);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got %h expected %h", j, obs, exp);
      end
      if (j == 28) begin
        n_checks++;
        if (bus.w_ptr !== 5'b00000) begin
          n_fail++;
          $display("FAIL wrap_ptr_zero: got %b expected 00000", bus.w_ptr);
        end
      end
    end
    bus.w_inc = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [16:0] exp;
    apply_reset();
    bus.w_inc = 1'b1;
    repeat (15) step();
    exp = pack(15, 15, 1'b0, 1'b0);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL b2b_level15: got %h expected %h", obs, exp);
    end
    bus.wq2_r_ptr = gray(1);
    step();
    exp = pack(16, 15, 1'b0, 1'b0);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL b2b_wr_rd: got %h expected %h", obs, exp);
    end
    step();
    exp = pack(17, 16, 1'b1, 1'b0);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL b2b_wr_to_full: got %h expected %h", obs, exp);
    end
    bus.w_inc = 1'b0;
  endtask

  initial begin
    bus.w_inc     = 1'b0;
    bus.w_ovf_clr = 1'b0;
    bus.wq2_r_ptr = '0;
    test_reset();
    test_reset_midcycle();
    test_fill_and_overflow();
    test_drain();
    test_wrap();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_wptr_full.md
Name: fifo_wptr_full

Overview:
- Write-side pointer and flag generator for the asynchronous FIFO. Runs entirely in the write clock domain.
- Directly feeds the dual-port storage array: drives its write address and full qualifier. The storage array's write enable is tied to w_inc.
- Consumes the read pointer after it has been resynchronised into the write domain, which arrives Gray-coded.
- Produces the Gray write pointer for the read-side synchroniser, plus fill level, almost-full and a sticky overflow flag.

Parameters:
- ADDR_WIDTH, 4, storage address width. Depth = 2^ADDR_WIDTH. Legal range is 2 or more.
- AFULL_THRESH, 12, fill level at or above which w_almost_full asserts. Legal range is 1..2^ADDR_WIDTH.

Ports:
- w_clk  input  1  write-domain clock. All state updates on the rising edge.
- w_rst  input  1  asynchronous, active-high reset. Clears all state immediately; synchronous behaviour resumes on the first w_clk edge after deassertion.
- w_inc  input  1  write request for this cycle. Also drives the storage array's write enable.
- wq2_r_ptr  input  ADDR_WIDTH+1  Gray-coded read pointer, already two-flop synchronised into w_clk.
- w_ovf_clr  input  1  clears w_overflow.
- w_addr  output  ADDR_WIDTH  write address to the storage array.
- w_ptr  output  ADDR_WIDTH+1  Gray-coded write pointer, sent to the read-domain synchroniser.
- w_full  output  1  FIFO full. Also goes to the storage array's full qualifier.
- w_almost_full  output  1  w_level >= AFULL_THRESH.
- w_level  output  ADDR_WIDTH+1  entries occupied, as seen from the write domain.
- w_overflow  output  1  sticky: a write was attempted while full.

Behaviour:
- Reset (asynchronous, active-high): w_bin, w_ptr, w_full, w_almost_full, w_level and w_overflow all clear to 0. As a result w_addr = 0.
- State: binary pointer w_bin, width ADDR_WIDTH+1.
- Write acceptance and pointer:
  - w_wr = w_inc & ~w_full.
  - w_bin_next = w_bin + w_wr, modulo 2^(ADDR_WIDTH+1). The pointer wraps from all-ones to 0 with no special case.
  - w_gray_next = (w_bin_next >> 1) ^ w_bin_next.
  - w_addr = w_bin[ADDR_WIDTH-1:0], taken directly from the register with no added latency. The word written this cycle goes to the current w_addr.
  - w_ptr is registered as w_gray_next. Exactly one bit changes per accepted write, and w_ptr is a glitch-free register output.
- Full flag:
  - w_full is registered: (w_gray_next == {~wq2_r_ptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_r_ptr[ADDR_WIDTH-2:0]}).
  - It asserts on the same edge that accepts the write filling the last slot.
  - It deasserts on the first edge at which the synchronised read pointer shows space. It is pessimistic by synchroniser latency and never optimistic.
- Level and almost-full:
  - r_bin = Gray-to-binary of wq2_r_ptr (XOR prefix from the MSB).
  - w_level is registered: w_bin_next - r_bin, modulo 2^(ADDR_WIDTH+1). Its range is 0..2^ADDR_WIDTH.
  - w_almost_full is registered: (w_bin_next - r_bin) >= AFULL_THRESH. It updates on the same edge as w_level.
- Overflow:
  - w_overflow sets on the edge where w_inc & w_full.
  - It clears on the edge where w_ovf_clr is high.
  - If set and clear occur in the same cycle, set wins.
- Write while full: the write is ignored. The pointer, w_ptr and w_level hold, and only w_overflow reacts.
- Simultaneous write and read-pointer advance in the same cycle: w_level reflects both (+1 and -k). w_full evaluates against the new read pointer.
- Reset mid-operation: all outputs drop to 0 asynchronously, mid-cycle. The read side is reset in the same event.
- w_inc held high continuously: one write is accepted per cycle until full.

Test Plan:
- Reset, then idle: hold w_rst=1 across a w_clk edge, then release → w_addr=0, w_ptr=0, w_full=0, w_level=0, w_almost_full=0, w_overflow=0. Asserting w_rst mid-cycle after 3 writes zeroes all outputs before the next edge.
- Fill from empty (ADDR_WIDTH=4, wq2_r_ptr=0): 16 consecutive w_inc → w_addr steps 0..15. w_ptr follows the Gray sequence 0,1,3,2,6,... and equals 5'b11000 after the 16th write. w_almost_full rises on the edge of the 12th write. w_full rises on the edge of the 16th write, with w_level=16.
- Overflow while full: one more w_inc while full → w_addr, w_ptr and w_level unchanged, w_overflow=1. Pulse w_ovf_clr → 0. w_inc and w_ovf_clr high together while full → w_overflow stays 1.
- Drain release: from full, step wq2_r_ptr through Gray 0→1→3 → w_full=0 one edge after the first change, w_level goes 16→15→14, and w_almost_full stays 1 until level drops below 12.
- Wrap-around: run 40 write/read cycles keeping level at 3 → w_bin wraps past 31→0. w_ptr returns to 5'b00000 after 32 writes, w_full never asserts, and w_level stays 3 throughout.
- Simultaneous events: at level 15, one write plus a read-pointer advance of 1 in the same cycle → level stays 15 and w_full stays 0. At level 15 with a write and no read → w_full=1.
